fft_frame_sched: RTL and testbench
==================================

// Module: fft_frame_sched
// PURPOSE
// - Time-shares one fft_1024_s core between two sample sources (ch A, ch B) on whole-frame granularity.
// - Round-robin frame arbiter, framing generator (di_en/di_last) for the FFT input, channel tag queue for the FFT output.
// - Sits between the test-pattern/ADC sources and the FFT core; output stream carries do_ch identifying the source frame.
// PARAMETERS
// - N_PT       1024  FFT frame length in samples (power of 2)
// - MIN_GAP    2     idle cycles forced on fft_di_en between consecutive frames (>=1)
// - TAG_DEPTH  4     frames in flight through the FFT (power of 2, >=2)
// PORTS
// - clk          in   1   clock, all logic rising-edge
// - rst          in   1   asynchronous, active-low reset
// - req_a        in   1   ch A has a full frame ready; sampled only in IDLE
// - req_b        in   1   ch B has a full frame ready; sampled only in IDLE
// - din_a        in   32  ch A sample {imag[31:16], real[15:0]}, valid in cycles where rd_a=1
// - din_b        in   32  ch B sample, same format
// - rd_a         out  1   sample strobe to ch A (combinational from state/owner)
// - rd_b         out  1   sample strobe to ch B
// - busy         out  1   1 when state != IDLE
// - fft_din      out  32  registered sample to FFT core
// - fft_di_en    out  1   registered sample valid to FFT core
// - fft_di_last  out  1   registered, high with sample N_PT-1 of a frame
// - fft_dout     in   32  FFT core output data
// - fft_do_en    in   1   FFT core output valid
// - fft_do_last  in   1   FFT core last output of a frame
// - dout         out  32  registered copy of fft_dout
// - do_en        out  1   registered copy of fft_do_en
// - do_last      out  1   registered copy of fft_do_last
// - do_ch        out  1   source of current output frame (0=A, 1=B), aligned with dout
// - frm_out_cnt  out  16  completed output frames, wraps at 65535->0
// - err_orphan   out  1   sticky: fft_do_en seen while tag queue empty; cleared only by rst
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, sample counter 0, tag queue empty, rr pointer = B (so A wins first tie).
// - FSM IDLE: if tag queue full -> stay. Else if req_a|req_b -> pick owner (single req wins; both -> opposite of last owner),
//   push owner tag, update rr pointer, go STREAM. Grant decision takes 1 cycle; rd_x asserts in first STREAM cycle.
// - STREAM: rd_owner=1 every cycle for exactly N_PT cycles, cnt 0..N_PT-1; req lines ignored, frame never aborted.
//   cnt==N_PT-1 -> go GAP (MIN_GAP-1 cycles) then IDLE; total idle on fft_di_en between frames >= MIN_GAP.
// - Input latency 1: fft_din/fft_di_en registered from owner din and rd; fft_di_last = registered (cnt==N_PT-1).
// - Tag queue: push at IDLE->STREAM, pop on fft_do_en & fft_do_last. do_ch = head tag registered alongside dout;
//   for the last sample do_ch still shows the popped tag. Simultaneous push+pop: occupancy unchanged, both applied.
// - Full queue blocks grants (no overflow possible). fft_do_en with empty queue -> err_orphan=1, do_ch=0, no pop.
// - Output path latency 1: dout/do_en/do_last = fft_* delayed one cycle. frm_out_cnt increments on do_last cycle.
// - Counter width clog2(N_PT); no arithmetic on samples (pass-through, no width change).
// - rst low mid-frame: immediate return to reset values; partial frame in FFT is not tracked (bench must also reset FFT).
// STRUCTURE
// - Shared package fft_pkg: N_PT_DEF=1024, CH_A=1'b0, CH_B=1'b1, state encoding ST_IDLE/ST_STREAM/ST_GAP.
// - One sub-module: fft_tag_fifo (TAG_DEPTH x 1-bit sync FIFO, push/pop/full/empty/head, async active-low rst).
// - Top holds FSM, round-robin pointer, sample counter, input and output registers, frame counter.
// TESTING
// - Only req_a held high, 3 frames -> rd_a high 1024 cycles each, fft_di_last on 1024th sample, >=2 idle between; do_ch=0 all outputs.
// - req_a and req_b both high from reset -> grant order A,B,A,B; do_ch frames 0,1,0,1; frm_out_cnt=4 after 4 do_last.
// - FFT model with latency > 4 frames, both reqs high -> after 4 grants busy stays 0 (IDLE) until first do_last pops, then grant resumes.
// - Drop req_a at sample 500 of its frame -> rd_a still covers all 1024 samples, fft_di_last at sample 1023.
// - Drive fft_do_en=1 with no frame granted -> err_orphan=1 next cycle, stays 1 until rst; do_ch=0.
// - Assert rst low at sample 300 of a frame -> all outputs 0 same cycle (async); after release, next grant goes to A.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame scheduler: defaults, channel tags, FSM states
// and the round-robin grant rule.
package fft_pkg;

  localparam int N_PT_DEF = 1024;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  // Single requester wins; on a tie the channel that did not go last wins.
  function automatic logic rr_pick(input logic ra, input logic rb, input logic last);
    if (ra && rb) return ~last;
    else if (rb)  return CH_B;
    else          return CH_A;
  endfunction

endpackage

// File: rtl/fft_tag_fifo.sv
// Small 1-bit-wide synchronous FIFO holding the source channel of each frame
// currently inside the FFT core.
module fft_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/fft_frame_sched.sv
// Whole-frame round-robin scheduler sharing one FFT core between two sample sources,
// with input framing and a channel tag queue to label the FFT output stream.
module fft_frame_sched
  import fft_pkg::*;
#(
  parameter int N_PT      = N_PT_DEF,
  parameter int MIN_GAP   = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [31:0] din_a,
  input  logic [31:0] din_b,
  output logic        rd_a,
  output logic        rd_b,
  output logic        busy,
  output logic [31:0] fft_din,
  output logic        fft_di_en,
  output logic        fft_di_last,
  input  logic [31:0] fft_dout,
  input  logic        fft_do_en,
  input  logic        fft_do_last,
  output logic [31:0] dout,
  output logic        do_en,
  output logic        do_last,
  output logic        do_ch,
  output logic [15:0] frm_out_cnt,
  output logic        err_orphan
);

  localparam int CW = $clog2(N_PT);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_PT - 1);
  // The IDLE grant cycle supplies one idle slot, GAP the remaining MIN_GAP-1.
  localparam int GAP_CYC = MIN_GAP - 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap_cnt;
  logic          rr_last;
  logic          grant;
  logic          pick;
  logic          tag_full;
  logic          tag_empty;
  logic          tag_head;
  logic          tag_pop;

  always_comb begin
    grant = (state == ST_IDLE) && !tag_full && (req_a || req_b);
    pick  = rr_pick(req_a, req_b, rr_last);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (grant) state_nxt = ST_STREAM;
      ST_STREAM: if (cnt == CNT_LAST) state_nxt = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:    if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_a = (state == ST_STREAM) && (rr_last == CH_A);
    rd_b = (state == ST_STREAM) && (rr_last == CH_B);
    busy = (state != ST_IDLE);
  end

  // rr_last doubles as the current owner while streaming.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      gap_cnt <= '0;
      rr_last <= CH_B;
    end else begin
      cnt     <= (state == ST_STREAM) ? cnt + CW'(1) : '0;
      gap_cnt <= (state == ST_GAP) ? gap_cnt + GW'(1) : '0;
      if (grant) rr_last <= pick;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fft_din     <= '0;
      fft_di_en   <= 1'b0;
      fft_di_last <= 1'b0;
    end else begin
      fft_din     <= rd_a ? din_a : (rd_b ? din_b : '0);
      fft_di_en   <= rd_a || rd_b;
      fft_di_last <= (state == ST_STREAM) && (cnt == CNT_LAST);
    end
  end

  assign tag_pop = fft_do_en && fft_do_last && !tag_empty;

  fft_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .pop   (tag_pop),
    .din   (pick),
    .full  (tag_full),
    .empty (tag_empty),
    .head  (tag_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout        <= '0;
      do_en       <= 1'b0;
      do_last     <= 1'b0;
      do_ch       <= 1'b0;
      frm_out_cnt <= '0;
      err_orphan  <= 1'b0;
    end else begin
      dout    <= fft_dout;
      do_en   <= fft_do_en;
      do_last <= fft_do_last;
      do_ch   <= (fft_do_en && !tag_empty) ? tag_head : CH_A;
      if (fft_do_en && fft_do_last) frm_out_cnt <= frm_out_cnt + 16'd1;
      if (fft_do_en && tag_empty)   err_orphan  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Self-checking bench: random sample data through a delay-line FFT model, grant order and
// output channel tags compared against a round-robin reference computed in the bench.
module tb_fft_frame_sched;
  import fft_pkg::*;

  localparam int NP = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [31:0] din_a = '0, din_b = '0;
  logic        rd_a, rd_b, busy;
  logic [31:0] fft_din;
  logic        fft_di_en, fft_di_last;
  logic [31:0] fft_dout;
  logic        fft_do_en, fft_do_last;
  logic [31:0] dout;
  logic        do_en, do_last, do_ch;
  logic [15:0] frm_out_cnt;
  logic        err_orphan;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // FFT model controls
  int          lat = 20;
  logic        manual = 1'b0;
  logic        man_en = 1'b0, man_last = 1'b0;
  logic [31:0] man_dout = '0;
  logic        mdl_en = 1'b0, mdl_last = 1'b0;
  logic [31:0] mdl_dout = '0;
  logic        data_chk = 1'b1;

  assign fft_do_en   = manual ? man_en   : mdl_en;
  assign fft_do_last = manual ? man_last : mdl_last;
  assign fft_dout    = manual ? man_dout : mdl_dout;

  fft_frame_sched #(.N_PT(NP), .MIN_GAP(2), .TAG_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .din_a(din_a), .din_b(din_b),
    .rd_a(rd_a), .rd_b(rd_b), .busy(busy), .fft_din(fft_din), .fft_di_en(fft_di_en),
    .fft_di_last(fft_di_last), .fft_dout(fft_dout), .fft_do_en(fft_do_en),
    .fft_do_last(fft_do_last), .dout(dout), .do_en(do_en), .do_last(do_last),
    .do_ch(do_ch), .frm_out_cnt(frm_out_cnt), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [31:0] d; logic last; } pipe_t;
  typedef struct { logic own; int len; int start; } run_t;

  // FFT core stand-in: fixed per-sample latency, cleared by reset
  pipe_t pipe[$];
  always @(negedge clk) begin
    pipe_t e;
    if (!rst) begin
      pipe.delete();
      mdl_en = 1'b0; mdl_last = 1'b0; mdl_dout = '0;
    end else begin
      if (fft_di_en) pipe.push_back('{cyc + lat, fft_din, fft_di_last});
      if (pipe.size() > 0 && pipe[0].due <= cyc) begin
        e = pipe.pop_front();
        mdl_en = 1'b1; mdl_last = e.last; mdl_dout = e.d;
      end else begin
        mdl_en = 1'b0; mdl_last = 1'b0;
      end
    end
  end

  // Observation logs, cleared while rst is low
  run_t        grant_q[$];
  int          last_pos_q[$];
  logic        out_ch_q[$];
  logic [31:0] exp_q[$];
  int   run_len = 0, runs_started = 0, run_start = 0;
  logic run_own = 1'b0;
  int   di_cnt = 0, idle_cnt = 0, min_gap = 1 << 30;
  bit   after_frm = 0, in_frm = 0;
  logic cur_ch = 1'b0;
  int   data_err = 0, ch_incons = 0, both_rd = 0;

  always @(negedge clk) begin
    logic [31:0] x;
    din_a = $urandom;
    din_b = $urandom;
    if (!rst) begin
      grant_q.delete(); last_pos_q.delete(); out_ch_q.delete(); exp_q.delete();
      run_len = 0; runs_started = 0; di_cnt = 0; idle_cnt = 0; min_gap = 1 << 30;
      after_frm = 0; in_frm = 0; data_err = 0; ch_incons = 0; both_rd = 0;
    end else begin
      if (rd_a && rd_b) both_rd++;
      if (rd_a || rd_b) begin
        if (run_len == 0) begin run_own = rd_b; run_start = cyc; runs_started++; end
        run_len++;
        exp_q.push_back(rd_b ? din_b : din_a);
      end else if (run_len != 0) begin
        grant_q.push_back('{run_own, run_len, run_start});
        run_len = 0;
      end
      if (fft_di_en) begin
        if (di_cnt == 0 && after_frm && idle_cnt < min_gap) min_gap = idle_cnt;
        di_cnt++;
        if (fft_di_last) begin
          last_pos_q.push_back(di_cnt);
          di_cnt = 0; after_frm = 1; idle_cnt = 0;
        end
      end else idle_cnt++;
      if (do_en) begin
        if (data_chk) begin
          if (exp_q.size() == 0) data_err++;
          else begin x = exp_q.pop_front(); if (dout !== x) data_err++; end
        end
        if (!in_frm) begin cur_ch = do_ch; in_frm = 1; end
        else if (do_ch !== cur_ch) ch_incons++;
        if (do_last) begin out_ch_q.push_back(cur_ch); in_frm = 0; end
      end
    end
  end

  // Reference arbitration rule
  function automatic logic next_owner(input logic ra, input logic rb, input logic prev);
    if (ra && !rb) return CH_A;
    if (rb && !ra) return CH_B;
    return (prev == CH_A) ? CH_B : CH_A;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0; manual = 1'b0; man_en = 1'b0; man_last = 1'b0; data_chk = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_started(input int n, input int bound, output bit ok);
    for (int i = 0; i < bound && runs_started < n; i++) @(negedge clk);
    ok = (runs_started >= n);
  endtask

  task automatic wait_done(input int ng, input int no, input int bound, output bit ok);
    for (int i = 0; i < bound && (grant_q.size() < ng || out_ch_q.size() < no); i++) @(negedge clk);
    ok = (grant_q.size() >= ng) && (out_ch_q.size() >= no);
  endtask

  task automatic test_reset();
    logic [88:0] ov;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    ov = {rd_a, rd_b, busy, fft_di_en, fft_di_last, fft_din, do_en, do_last, do_ch, dout, frm_out_cnt, err_orphan};
    checks++;
    if (ov !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", ov); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_a();
    bit ok;
    do_reset();
    lat = 20;
    req_a = 1'b1;
    wait_started(3, 4000, ok);
    req_a = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL single_a_start: got %0d grants expected 3", runs_started); end
    wait_done(3, 3, 3000, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (grant_q.size() != 3 || out_ch_q.size() != 3) begin
      errors++; $display("FAIL single_a_count: got %0d/%0d frames expected 3/3", grant_q.size(), out_ch_q.size());
    end
    for (int i = 0; i < grant_q.size() && i < 3; i++) begin
      checks++;
      if (grant_q[i].own !== CH_A || grant_q[i].len != NP) begin
        errors++; $display("FAIL single_a_frame%0d: got own %b len %0d expected 0 %0d", i, grant_q[i].own, grant_q[i].len, NP);
      end
    end
    for (int i = 0; i < last_pos_q.size(); i++) begin
      checks++;
      if (last_pos_q[i] != NP) begin errors++; $display("FAIL single_a_last%0d: got %0d expected %0d", i, last_pos_q[i], NP); end
    end
    for (int i = 0; i < out_ch_q.size(); i++) begin
      checks++;
      if (out_ch_q[i] !== CH_A) begin errors++; $display("FAIL single_a_do_ch%0d: got %b expected 0", i, out_ch_q[i]); end
    end
    checks++;
    if (min_gap < 2) begin errors++; $display("FAIL single_a_gap: got %0d expected >=2", min_gap); end
    checks++;
    if (frm_out_cnt !== 16'd3) begin errors++; $display("FAIL single_a_frm_cnt: got %0d expected 3", frm_out_cnt); end
    checks++;
    if (data_err != 0 || ch_incons != 0 || both_rd != 0) begin
      errors++; $display("FAIL single_a_data: got %0d/%0d/%0d errs expected 0", data_err, ch_incons, both_rd);
    end
  endtask

  task automatic test_both_rr();
    bit ok;
    logic prev, e;
    do_reset();
    lat = 20;
    req_a = 1'b1; req_b = 1'b1;
    wait_started(4, 5000, ok);
    req_a = 1'b0; req_b = 1'b0;
    wait_done(4, 4, 3000, ok);
    checks++;
    if (!ok || grant_q.size() != 4) begin errors++; $display("FAIL rr_count: got %0d grants expected 4", grant_q.size()); end
    prev = CH_B;
    for (int i = 0; i < grant_q.size() && i < 4 && i < out_ch_q.size(); i++) begin
      e = next_owner(1'b1, 1'b1, prev);
      prev = e;
      checks++;
      if (grant_q[i].own !== e || out_ch_q[i] !== e) begin
        errors++; $display("FAIL rr_order%0d: got grant %b do_ch %b expected %b", i, grant_q[i].own, out_ch_q[i], e);
      end
    end
    checks++;
    if (frm_out_cnt !== 16'd4) begin errors++; $display("FAIL rr_frm_cnt: got %0d expected 4", frm_out_cnt); end
    checks++;
    if (data_err != 0 || ch_incons != 0) begin errors++; $display("FAIL rr_data: got %0d/%0d errs expected 0", data_err, ch_incons); end
  endtask

  task automatic test_queue_full();
    bit ok, seen;
    int busy_cnt, pop_cyc, started_at_pop;
    logic prev, e;
    do_reset();
    lat = 5 * (NP + 2) + 50;
    req_a = 1'b1; req_b = 1'b1;
    wait_started(4, 5000, ok);
    wait_done(4, 0, 2000, ok);
    repeat (3) @(negedge clk);
    busy_cnt = 0; seen = 0; pop_cyc = 0;
    for (int i = 0; i < 8000 && !seen; i++) begin
      @(negedge clk);
      if (do_last) begin seen = 1; pop_cyc = cyc; end
      else if (busy) busy_cnt++;
    end
    started_at_pop = runs_started;
    checks++;
    if (!seen) begin errors++; $display("FAIL qfull_pop: got no do_last expected one"); end
    checks++;
    if (busy_cnt != 0 || started_at_pop != 4) begin
      errors++; $display("FAIL qfull_block: got busy %0d cycles, %0d grants expected 0, 4", busy_cnt, started_at_pop);
    end
    wait_started(5, 10, ok);
    req_a = 1'b0; req_b = 1'b0;
    checks++;
    if (!ok || run_start - pop_cyc > 3) begin
      errors++; $display("FAIL qfull_resume: got start %0d pop %0d expected within 3", run_start, pop_cyc);
    end
    wait_done(5, 5, 15000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL qfull_drain: got %0d frames out expected 5", out_ch_q.size()); end
    prev = CH_B;
    for (int i = 0; i < out_ch_q.size() && i < 5; i++) begin
      e = next_owner(1'b1, 1'b1, prev);
      prev = e;
      checks++;
      if (out_ch_q[i] !== e) begin errors++; $display("FAIL qfull_do_ch%0d: got %b expected %b", i, out_ch_q[i], e); end
    end
  endtask

  task automatic test_drop_req();
    bit ok;
    do_reset();
    lat = 20;
    req_a = 1'b1;
    for (int i = 0; i < 600 && run_len < 500; i++) @(negedge clk);
    req_a = 1'b0;
    wait_done(1, 1, 2000, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (grant_q.size() != 1 || last_pos_q.size() != 1) begin
      errors++; $display("FAIL drop_count: got %0d grants %0d lasts expected 1 1", grant_q.size(), last_pos_q.size());
    end else begin
      checks++;
      if (grant_q[0].len != NP || grant_q[0].own !== CH_A || last_pos_q[0] != NP) begin
        errors++; $display("FAIL drop_frame: got len %0d last %0d expected %0d %0d", grant_q[0].len, last_pos_q[0], NP, NP);
      end
    end
  endtask

  task automatic test_orphan();
    do_reset();
    data_chk = 1'b0;
    manual = 1'b1;
    @(negedge clk);
    man_dout = $urandom; man_en = 1'b1; man_last = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (err_orphan !== 1'b1 || do_ch !== 1'b0 || do_en !== 1'b1) begin
      errors++; $display("FAIL orphan_set: got err %b do_ch %b do_en %b expected 1 0 1", err_orphan, do_ch, do_en);
    end
    @(negedge clk);
    man_en = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b expected 1", err_orphan); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_clear: got %b expected 0", err_orphan); end
    manual = 1'b0;
    do_reset();
  endtask

  task automatic test_mid_reset();
    bit ok;
    logic [88:0] ov;
    do_reset();
    lat = 20;
    req_b = 1'b1;
    for (int i = 0; i < 400 && run_len < 300; i++) @(negedge clk);
    req_b = 1'b0;
    #2 rst = 1'b0;
    #1;
    ov = {rd_a, rd_b, busy, fft_di_en, fft_di_last, fft_din, do_en, do_last, do_ch, dout, frm_out_cnt, err_orphan};
    checks++;
    if (ov !== '0) begin errors++; $display("FAIL midrst_outputs: got %h expected 0", ov); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    req_a = 1'b1; req_b = 1'b1;
    wait_started(1, 10, ok);
    req_a = 1'b0; req_b = 1'b0;
    checks++;
    if (!ok || run_own !== CH_A) begin errors++; $display("FAIL midrst_first_grant: got %b expected 0", run_own); end
    wait_done(1, 1, 2000, ok);
    checks++;
    if (!ok || out_ch_q[0] !== CH_A || data_err != 0) begin
      errors++; $display("FAIL midrst_out: got %0d frames %0d data errs expected 1 0", out_ch_q.size(), data_err);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic prev, ra, rb;
    logic [1:0] v;
    logic exp_own[$];
    do_reset();
    lat = $urandom_range(5, 60);
    prev = CH_B;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 1200 && busy; i++) @(negedge clk);
      v = 2'($urandom_range(1, 3));
      ra = v[0]; rb = v[1];
      req_a = ra; req_b = rb;
      prev = next_owner(ra, rb, prev);
      exp_own.push_back(prev);
      wait_started(k + 1, 10, ok);
      req_a = 1'b0; req_b = 1'b0;
    end
    wait_done(6, 6, 3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rand_count: got %0d/%0d frames expected 6/6", grant_q.size(), out_ch_q.size()); end
    for (int i = 0; i < 6 && i < grant_q.size() && i < out_ch_q.size(); i++) begin
      checks++;
      if (grant_q[i].own !== exp_own[i] || out_ch_q[i] !== exp_own[i]) begin
        errors++; $display("FAIL rand_owner%0d: got grant %b do_ch %b expected %b", i, grant_q[i].own, out_ch_q[i], exp_own[i]);
      end
    end
    checks++;
    if (data_err != 0 || ch_incons != 0 || both_rd != 0) begin
      errors++; $display("FAIL rand_data: got %0d/%0d/%0d errs expected 0", data_err, ch_incons, both_rd);
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_both_rr();
    test_queue_full();
    test_drop_req();
    test_orphan();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
